// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-requester data-memory arbiter.
package dmem_arbiter_pkg;

  localparam int MEM_WORDS_DEF = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Two-way round-robin pick: ptr=1 favours requester 1 when both request.
module rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || !ptr)) gnt = 2'b01;
    else if (req[1])                 gnt = 2'b10;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: round-robin between core and loader, with lock for
// read-modify-write and one-cycle registered read responses.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic              m0_lock,
  input  logic              m1_lock,
  input  logic [DATA_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m0_err,
  output logic              m1_err,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [DATA_W-1:0] LIMIT = DATA_W'(MEM_WORDS);

  arb_state_t                   state;
  logic                         ptr;
  logic [1:0]                   req, we, lock, oor, req_eff, pick, gnt, rsp;
  logic [1:0][DATA_W-1:0]       addr, wdata, rdata_q;
  logic [1:0]                   rvalid_q, err_q;
  logic                         sel, any;

  assign req   = {m1_req, m0_req};
  assign we    = {m1_we, m0_we};
  assign lock  = {m1_lock, m0_lock};
  assign addr  = {m1_addr, m0_addr};
  assign wdata = {m1_wdata, m0_wdata};

  always_comb begin
    for (int n = 0; n < 2; n++) oor[n] = (addr[n] >> 2) >= LIMIT;
  end

  // A lock hides the other requester from the pick entirely.
  always_comb begin
    req_eff = req;
    case (state)
      LOCK0:   req_eff = {1'b0, req[0]};
      LOCK1:   req_eff = {req[1], 1'b0};
      default: req_eff = req;
    endcase
  end

  rr_pick u_pick (
    .req (req_eff),
    .ptr (ptr),
    .gnt (pick)
  );

  assign gnt    = rst ? pick : 2'b00;
  assign sel    = gnt[1];
  assign any    = |gnt;
  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];
  // Reads and out-of-range accesses return a response next cycle.
  assign rsp    = gnt & (~we | oor);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (any) begin
      mem_addr  = addr[sel];
      mem_wdata = wdata[sel];
      mem_read  = ~oor[sel] & ~we[sel];
      mem_write = ~oor[sel] &  we[sel];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      if (any) ptr <= gnt[0];
      case (state)
        IDLE: begin
          if (gnt[0] && lock[0])      state <= LOCK0;
          else if (gnt[1] && lock[1]) state <= LOCK1;
        end
        LOCK0:   if (!req[0] || (gnt[0] && !lock[0])) state <= IDLE;
        LOCK1:   if (!req[1] || (gnt[1] && !lock[1])) state <= IDLE;
        default: state <= IDLE;
      endcase
      rvalid_q <= rsp;
      err_q    <= gnt & oor;
      for (int n = 0; n < 2; n++)
        if (rsp[n]) rdata_q[n] <= oor[n] ? '0 : mem_rdata;
    end
  end

  // A reset cycle swallows any response still in flight.
  assign m0_rvalid = rvalid_q[0] & rst;
  assign m1_rvalid = rvalid_q[1] & rst;
  assign m0_err    = err_q[0] & rst;
  assign m1_err    = err_q[1] & rst;
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, data and address width; MEM_WORDS, default 128, number of data-memory words; a word index >= MEM_WORDS is out of range.
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock; all state updates on posedge clk
  rst  input  1  synchronous, active-low reset, sampled on posedge clk
  m0_req, m1_req  input  1  requester 0 (core load/store) / requester 1 (loader/DMA) access request
  m0_we, m1_we  input  1  1 = write, 0 = read
  m0_lock, m1_lock  input  1  keep grant after this access (read-modify-write)
  m0_addr, m1_addr  input  DATA_W  byte address; word index = addr[31:2]
  m0_wdata, m1_wdata  input  DATA_W  write data
  m0_gnt, m1_gnt  output  1  access accepted this cycle (combinational)
  m0_rvalid, m1_rvalid  output  1  read data / error valid, one cycle after grant
  m0_rdata, m1_rdata  output  DATA_W  registered read data
  m0_err, m1_err  output  1  out-of-range response, qualified by rvalid
  mem_addr  output  DATA_W  address to data memory
  mem_wdata  output  DATA_W  write data to data memory
  mem_read  output  1  memory read enable
  mem_write  output  1  memory write enable; memory writes on posedge clk
  mem_rdata  input  DATA_W  combinational read data from memory

Function
REQ-003 At most one of m0_gnt/m1_gnt SHALL be high in any cycle; a grant SHALL only be given to a requester whose req is high.
REQ-004 Arbitration SHALL be round-robin: one requester -> that requester; both requesting -> the requester not granted most recently; the priority pointer SHALL update only on a granted cycle.
REQ-005 State machine SHALL have states IDLE, LOCK0, LOCK1; IDLE -> LOCKn when requester n is granted with mn_lock=1; LOCKn -> IDLE when requester n is granted with mn_lock=0, or when mn_req=0 for one cycle.
REQ-006 In LOCKn, only requester n SHALL be granted; the other requester's req SHALL be ignored and stalled.
REQ-007 Granted cycle, in range: mem_addr/mem_wdata SHALL mirror the granted requester; mem_read=~we; mem_write=we.
REQ-008 Granted cycle, out of range: mem_read=0, mem_write=0, no memory state changes; the grant still completes.
REQ-009 No grant: mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-010 Read latency SHALL be 1 cycle: mem_rdata is registered at the grant edge; mn_rvalid=1 and mn_rdata valid in the following cycle only.
REQ-011 A granted write SHALL produce no rvalid, unless out of range: then rvalid=1 and err=1 the next cycle.
REQ-012 Out-of-range read SHALL return rdata=0, err=1 with rvalid.
REQ-013 rdata SHALL hold its last value while rvalid=0; err SHALL be 0 when rvalid=0.
REQ-014 Back-to-back grants SHALL be supported every cycle, with no bubble, including alternating requesters.

Reset
REQ-015 With rst=0 at a posedge: state=IDLE; priority pointer favours requester 0; all rvalid, err and rdata=0.
REQ-016 During a reset cycle no grant and no memory write SHALL occur; an access granted the cycle before reset SHALL lose its rvalid; a lock SHALL be dropped.

Structure
REQ-017 State encoding (IDLE/LOCK0/LOCK1) and the default MEM_WORDS SHALL live in the shared datapath package.
REQ-018 A single sub-module rr_pick SHALL hold the 2-way round-robin pick (inputs req pair and pointer, output one-hot grant); the FSM, response registers and memory mux stay in dmem_arbiter.

Verification
REQ-019 Reset, then m0 read addr 0x8 with memory word 2 = 2 -> m0_gnt same cycle; m0_rvalid=1, m0_rdata=2, m0_err=0 next cycle.
REQ-020 Both requesting reads every cycle for 4 cycles after reset -> grants m0, m1, m0, m1; each rvalid exactly one cycle after its grant.
REQ-021 m1 write 0xDEAD to addr 0x10, then m0 read 0x10 -> m0_rdata=0xDEAD; the write produces no m1_rvalid.
REQ-022 m0 lock read 0x4 and then unlocked write 0x4, while m1_req is held high -> m1 gets no grant until the cycle after the unlocked write.
REQ-023 m1 read addr 0x200 (index 128) -> mem_read=0; next cycle m1_rvalid=1, m1_err=1, m1_rdata=0; a write to 0x200 leaves memory unchanged.
REQ-024 rst=0 asserted in the cycle after an m0 read grant while in LOCK0 -> no m0_rvalid, state IDLE, and the next simultaneous request is granted to m0.
